// File: rtl/mem_subsystem_pkg.sv
// Shared types and constants for the memory subsystem.
//   ldState_t    : boot loader FSM states
//   MMIO_*       : MMIO word offsets decoded on ALUResultM[3:2]
//   MMIO_SEL_BIT : address bit selecting the MMIO window over DMEM
package mem_subsystem_pkg;

  typedef enum logic [1:0] {
    LEN0 = 2'd0,
    LEN1 = 2'd1,
    DATA = 2'd2,
    RUN  = 2'd3
  } ldState_t;

  localparam logic [1:0] MMIO_LED    = 2'd0;
  localparam logic [1:0] MMIO_CYCLE  = 2'd1;
  localparam logic [1:0] MMIO_TOHOST = 2'd2;

  localparam int MMIO_SEL_BIT = 31;

endpackage

// File: rtl/mem_subsystem_boot_loader.sv
// Byte-stream boot loader. Receives a 16-bit little-endian word count N,
// then 4N little-endian instruction bytes, and emits one IMEM write per
// completed word. Holds the core in reset until the stream is consumed.
//   clk, reset       : clock, synchronous active-high reset
//   ldValid, ldByte  : incoming byte stream
//   ldReady          : high while the loader still accepts bytes
//   cpuReset         : core reset, released once RUN is reached
//   imemWe/Idx/Data  : IMEM write port, valid on the edge it is asserted
module boot_loader
  import mem_subsystem_pkg::*;
#(
  parameter int IMEM_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ldValid,
  input  logic [7:0]                    ldByte,
  output logic                          ldReady,
  output logic                          cpuReset,
  output logic                          imemWe,
  output logic [$clog2(IMEM_WORDS)-1:0] imemIdx,
  output logic [31:0]                   imemData
);

  localparam int IW = $clog2(IMEM_WORDS);

  ldState_t    state, stateNxt;
  logic [15:0] wordCount;
  logic [15:0] wordIdx;
  logic [1:0]  byteIdx;
  logic [23:0] asmBuf;   // first three bytes of the current word
  logic        xfer;
  logic        lastByteOfWord;

  assign ldReady        = (state != RUN);
  assign cpuReset       = (state != RUN);
  assign xfer           = ldValid && ldReady;
  assign lastByteOfWord = (state == DATA) && (byteIdx == 2'd3);

  // Words past the end of IMEM are still consumed, just never written.
  assign imemWe   = xfer && lastByteOfWord && (32'(wordIdx) < 32'(IMEM_WORDS));
  assign imemIdx  = wordIdx[IW-1:0];
  assign imemData = {ldByte, asmBuf};

  always_ff @(posedge clk) begin
    if (reset) state <= LEN0;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      LEN0: if (xfer) stateNxt = LEN1;
      LEN1: if (xfer) stateNxt = ({ldByte, wordCount[7:0]} == 16'd0) ? RUN : DATA;
      DATA: if (xfer && lastByteOfWord && (wordIdx == wordCount - 16'd1)) stateNxt = RUN;
      default: stateNxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wordCount <= '0;
      wordIdx   <= '0;
      byteIdx   <= '0;
      asmBuf    <= '0;
    end else if (xfer) begin
      case (state)
        LEN0: wordCount[7:0] <= ldByte;
        LEN1: begin
          wordCount[15:8] <= ldByte;
          wordIdx         <= '0;
          byteIdx         <= '0;
        end
        DATA: begin
          if (byteIdx == 2'd3) begin
            byteIdx <= '0;
            wordIdx <= wordIdx + 16'd1;
          end else begin
            // Shift in from the top: after three bytes asmBuf = {b2,b1,b0}.
            asmBuf  <= {ldByte, asmBuf[23:8]};
            byteIdx <= byteIdx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_subsystem.sv
// Memory-side responder for the pipelined core: instruction RAM (fetch
// port), data RAM plus MMIO window (data port), and the boot loader that
// fills IMEM before releasing the core.
//   clk, reset                      : clock, synchronous active-high reset
//   cpu_reset                       : core reset, high until load completes
//   PCF / InstrF                    : combinational instruction fetch
//   MemWriteM/ALUResultM/WriteDataM : data store port
//   ReadDataM                       : combinational load data
//   ld_valid/ld_byte/ld_ready       : loader byte stream
//   leds, halted, tohost            : MMIO-visible state
module mem_subsystem
  import mem_subsystem_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic [7:0]  leds,
  output logic        halted,
  output logic [31:0] tohost
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic          imemWe;
  logic [IW-1:0] imemIdx;
  logic [31:0]   imemData;
  logic [DW-1:0] dIdx;
  logic [1:0]    mmioOff;
  logic          isMmio;
  logic [31:0]   cycleCnt;
  logic          unusedAddrBits;

  boot_loader #(.IMEM_WORDS(IMEM_WORDS)) uLoader (
    .clk      (clk),
    .reset    (reset),
    .ldValid  (ld_valid),
    .ldByte   (ld_byte),
    .ldReady  (ld_ready),
    .cpuReset (cpu_reset),
    .imemWe   (imemWe),
    .imemIdx  (imemIdx),
    .imemData (imemData)
  );

  // High address bits alias; byte offset within a word is ignored.
  assign unusedAddrBits = ^{PCF[31:IW+2], PCF[1:0],
                            ALUResultM[30:DW+2], ALUResultM[1:0]};

  assign dIdx    = ALUResultM[DW+1:2];
  assign mmioOff = ALUResultM[3:2];
  assign isMmio  = ALUResultM[MMIO_SEL_BIT];

  // RAMs are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (imemWe) imem[imemIdx] <= imemData;
  end

  always_ff @(posedge clk) begin
    if (MemWriteM && !isMmio) dmem[dIdx] <= WriteDataM;
  end

  assign InstrF = imem[PCF[IW+1:2]];

  always_ff @(posedge clk) begin
    if (reset) begin
      leds   <= '0;
      halted <= 1'b0;
      tohost <= '0;
    end else if (MemWriteM && isMmio) begin
      if (mmioOff == MMIO_LED) leds <= WriteDataM[7:0];
      if (mmioOff == MMIO_TOHOST) begin
        tohost <= WriteDataM;
        halted <= 1'b1;
      end
    end
  end

  // Held at zero while the core is in reset, so it reads 0 in the first
  // RUN cycle and counts every RUN cycle after that.
  always_ff @(posedge clk) begin
    if (reset || cpu_reset) cycleCnt <= '0;
    else                    cycleCnt <= cycleCnt + 32'd1;
  end

  always_comb begin
    ReadDataM = dmem[dIdx];
    if (isMmio) begin
      case (mmioOff)
        MMIO_LED:    ReadDataM = {24'd0, leds};
        MMIO_CYCLE:  ReadDataM = cycleCnt;
        MMIO_TOHOST: ReadDataM = tohost;
        default:     ReadDataM = '0;
      endcase
    end
  end

endmodule

// File: doc/mem_subsystem.md
# mem_subsystem

Memory-side responder for the pipelined RISC-V core: serves the core's instruction fetch port (PCF → InstrF) and data port (ALUResultM/WriteDataM/MemWriteM → ReadDataM). Contains word-addressed instruction RAM, data RAM, a small MMIO window (LED register, cycle counter, halt/tohost), and a byte-stream boot loader. The boot loader fills instruction RAM and holds the core in reset until loading completes. Sits directly under the SoC top, beside the core instance.

## Interface
- IMEM_WORDS, 256, instruction RAM depth in 32-bit words (power of two)
- DMEM_WORDS, 256, data RAM depth in 32-bit words (power of two)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_reset  out  1  reset to core; high until load completes
- PCF  in  32  fetch byte address
- InstrF  out  32  fetched instruction
- MemWriteM  in  1  data write strobe
- ALUResultM  in  32  data byte address
- WriteDataM  in  32  store data
- ReadDataM  out  32  load data
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte
- ld_ready  out  1  loader can accept a byte
- leds  out  8  LED register
- halted  out  1  tohost written
- tohost  out  32  last value written to tohost

## Operation
- Word index: IMEM uses PCF[log2(IMEM_WORDS)+1:2]; DMEM uses ALUResultM[log2(DMEM_WORDS)+1:2]; upper bits ignored (aliasing), low two bits ignored.
- Reads are combinational: InstrF and ReadDataM reflect the current address in the same cycle. The core consumes them without a handshake.
- Address decode on ALUResultM[31]:
  - 0: DMEM. Store writes the full word at the clock edge when MemWriteM=1.
  - 1: MMIO, decoded on ALUResultM[3:2]:
    - 0 LED: write sets leds=WriteDataM[7:0]; read returns {24'b0, leds}.
    - 1 cycle counter: read-only; writes are ignored.
    - 2 tohost: write sets tohost=WriteDataM and halted=1; read returns tohost.
    - 3: reads 0, writes ignored.
- MMIO writes never modify DMEM.
- Boot loader FSM, states LEN0 → LEN1 → DATA → RUN:
  - LEN0/LEN1 accept the low and high bytes of 16-bit word count N.
  - DATA accepts 4N bytes, little-endian per word. The 4th byte of word k writes IMEM[k] on that same edge.
  - Words with k ≥ IMEM_WORDS are consumed but discarded.
  - If N=0, LEN1 goes directly to RUN.
- ld_ready=1 in LEN0, LEN1 and DATA; 0 in RUN. A byte transfers on an edge with ld_valid && ld_ready. Bytes offered in RUN are ignored.
- cpu_reset=1 in every state except RUN.
- Cycle counter: 32 bits, cleared to 0 when RUN is entered, +1 each RUN cycle, wraps 0xFFFFFFFF → 0.
- halted is sticky until reset. It does not stop the counter or the core.

## Timing
- Reset values:
  - state=LEN0, cpu_reset=1, ld_ready=1
  - leds=0, halted=0, tohost=0, counter=0
  - internal byte/word counters=0
- RAM contents are not cleared by reset.
- Reset during load returns to LEN0. IMEM words already written persist; the partially assembled word is dropped.
- The last byte is accepted on edge E. From E, state=RUN and cpu_reset=0. The counter reads 0 in the cycle after E and 1 in the next.
- Store then load to the same address: the load in the cycle after the write edge returns the new data. Same-cycle read returns the old data.
- A write to tohost on edge E gives halted=1 from E.

## Structure
- Package mem_subsystem_pkg holds:
  - the loader state enum
  - MMIO offsets: LED=0, CYCLE=1, TOHOST=2
  - MMIO select bit (31)
- Sub-module boot_loader: FSM, byte/word assembly and the IMEM write port (we, index, data), plus cpu_reset and ld_ready.
- RAMs, MMIO registers and the read mux live in mem_subsystem.

## Test plan
- Load N=2, bytes 13 00 00 00 / 93 00 10 00 → IMEM[0]=0x00000013, IMEM[1]=0x00100093. cpu_reset falls on the edge accepting the 10th byte; ld_ready then stays 0.
- Load N=0 (bytes 00 00) → RUN after the 2nd byte; counter reads 0,1,2 over subsequent cycles.
- Store 0xDEADBEEF to 0x00000010, then load from 0x00000010 and from alias 0x00000410 (DMEM_WORDS=256) → both return 0xDEADBEEF.
- Store 0x1A5 to 0x80000000 → leds=0xA5, DMEM[0] unchanged. Store 0x1 to 0x80000008 → halted=1, tohost=1.
- Reset after 5 loader bytes, then a full N=1 load of 0x00000033 → IMEM[0]=0x00000033 and the FSM restarted at LEN0.
- Load with IMEM_WORDS=4 and N=5 → 20 bytes consumed, IMEM[0..3] written, 5th word discarded, RUN reached.
